extram_sram16_ctrl: RTL
=======================

// Module: extram_sram16_ctrl
// PURPOSE
//  Downstream stage of the SoC extram port (0x0400_0000..0x0407_FFFC, 512 KB). Converts each 32-bit
//  valid/ready request into two timed accesses on an external asynchronous 16-bit SRAM (256K x 16).
//  Applies byte strobes, assembles read halves into one word and pulses extram_ready for one cycle.
// PARAMETERS
//  ADDR_BITS    18  SRAM halfword address width; word index taken from extram_addr[ADDR_BITS:2]
//  WAIT_CYCLES  2   strobe (WE_n/OE_n active) cycles per half access, range 0..15
// PORTS
//  clk            in   1   system clock
//  resetn         in   1   reset, asynchronous, active-low
//  extram_valid   in   1   request valid; held stable by master until ready
//  extram_ready   out  1   one-cycle completion pulse
//  extram_wstrb   in   4   byte write strobes; 4'b0000 = read
//  extram_addr    in   32  byte address; bits [1:0] and above ADDR_BITS ignored
//  extram_wdata   in   32  write data
//  extram_rdata   out  32  read data, valid while extram_ready=1
//  sram_addr      out  ADDR_BITS  halfword address
//  sram_dq_do     out  16  data to SRAM
//  sram_dq_oe     out  1   pad output enable for sram_dq_do
//  sram_dq_di     in   16  data from SRAM
//  sram_ce_n      out  1   chip enable, active-low
//  sram_oe_n      out  1   output enable, active-low
//  sram_we_n      out  1   write enable, active-low
//  sram_lb_n      out  1   lower byte enable, active-low
//  sram_ub_n      out  1   upper byte enable, active-low
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; ce_n/oe_n/we_n/lb_n/ub_n=1, dq_oe=0, sram_addr=0,
//    sram_dq_do=0, extram_ready=0, extram_rdata=0. All SRAM-side outputs registered (glitch-free).
//  - FSM: IDLE -> SETUP -> STROBE -> HOLD -> (next half: SETUP) | DONE -> IDLE.
//  - IDLE: on extram_valid latch addr/wdata/wstrb, select first half, go SETUP.
//  - Half 0 = low (sram_addr={word,1'b0}, data [15:0], strobes wstrb[1:0]);
//    half 1 = high (sram_addr={word,1'b1}, data [31:16], strobes wstrb[3:2]).
//  - Write: a half whose two strobes are both 0 is skipped; wstrb=4'b0000 is always a read of both.
//  - SETUP (1 cycle): ce_n=0, addr valid; write: dq_oe=1, lb_n/ub_n=~strobes, we_n=1;
//    read: lb_n=ub_n=0, oe_n=0, dq_oe=0.
//  - STROBE (WAIT_CYCLES cycles; 0 => state skipped): write: we_n=0; read: oe_n=0.
//  - HOLD (1 cycle): we_n=1, addr/data/dq_oe held; read: capture sram_dq_di into the half's rdata slice.
//  - After last needed half: DONE (1 cycle) extram_ready=1 with assembled rdata; then IDLE,
//    all controls inactive, dq_oe=0. Master drops valid after ready, so IDLE never re-issues.
//  - Latency valid->ready: full word = 2*(WAIT_CYCLES+2)+1 cycles (9 @ default);
//    single-half write = WAIT_CYCLES+3 cycles (5 @ default).
//  - dq_oe never 1 while oe_n=0; between halves we_n returns high for >=2 cycles (HOLD+SETUP).
//  - extram_rdata holds last read value until next read completes; writes leave it unchanged.
//  - Address wrap: 0x0407_FFFC maps to halfwords 0x3FFFE/0x3FFFF; no range check (decode is upstream).
//  - Reset mid-access: abandons transaction, no ready pulse; partial SRAM write permitted.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/SETUP/STROBE/HOLD/DONE), HALF_LO/HALF_HI constants,
//    SRAM_DATA_W=16.
//  - One sub-module: extram_wait_counter (load WAIT_CYCLES, decrement, done flag) for STROBE timing.
// TESTING
//  - Reset: assert resetn=0 mid-run -> ce_n/oe_n/we_n/lb_n/ub_n=1, dq_oe=0, ready=0 same cycle.
//  - Read 0x0400_0010, model lo@0x00008=0xBEEF, hi@0x00009=0xDEAD -> rdata 0xDEADBEEF, ready 1 cycle,
//    9 cycles after valid.
//  - Write 0x1234_5678 wstrb 4'b1111 to 0x0407_FFFC -> 0x5678@0x3FFFE, 0x1234@0x3FFFF,
//    we_n low exactly 2 cycles per half.
//  - Write wstrb 4'b0100 data 0x00AB_0000 to 0x0400_0000 -> only hi half, lb_n=0 ub_n=1, ready after
//    5 cycles, halfword 0x00000 untouched.
//  - WAIT_CYCLES=0 build: back-to-back read then write -> ready after 5 cycles each, no STROBE state,
//    dq_oe=0 whenever oe_n=0.
//  - resetn low during write STROBE, then read same address -> no ready for aborted write,
//    read completes normally.

Source files
------------

// File: rtl/extram_sram16_ctrl_pkg.sv
// Shared types and constants for the 32-bit to 16-bit external SRAM controller.
package extram_sram16_ctrl_pkg;

   localparam int unsigned SRAM_DATA_W = 16;
   localparam int unsigned WAIT_CNT_W  = 4;
   localparam int unsigned BUS_DATA_W  = 32;
   localparam int unsigned BUS_STRB_W  = 4;

   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [BUS_STRB_W-1:0] wstrb;
      logic [BUS_DATA_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/extram_sram16_ctrl_wait.sv
// Strobe-phase timer: loaded in SETUP, counts down through STROBE, flags the last cycle.
module extram_wait_counter
   import extram_sram16_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic load,
   input  logic en,
   output logic done_c
);

   localparam logic [WAIT_CNT_W-1:0] LOAD_VAL =
      (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

   logic [WAIT_CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         cnt <= '0;
      else if (load)
         cnt <= LOAD_VAL;
      else if (en && (cnt != '0))
         cnt <= cnt - WAIT_CNT_W'(1);
   end

   assign done_c = (cnt == '0);

endmodule

// File: rtl/extram_sram16_ctrl.sv
// Splits each 32-bit extram request into two timed halfword accesses on an async 16-bit SRAM.
module extram_sram16_ctrl
   import extram_sram16_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_BITS   = 18,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   extram_valid,
   output logic                   extram_ready,
   input  logic [BUS_STRB_W-1:0]  extram_wstrb,
   input  logic [31:0]            extram_addr,
   input  logic [BUS_DATA_W-1:0]  extram_wdata,
   output logic [BUS_DATA_W-1:0]  extram_rdata,
   output logic [ADDR_BITS-1:0]   sram_addr,
   output logic [SRAM_DATA_W-1:0] sram_dq_do,
   output logic                   sram_dq_oe,
   input  logic [SRAM_DATA_W-1:0] sram_dq_di,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_we_n,
   output logic                   sram_lb_n,
   output logic                   sram_ub_n
);

   state_e                 state, state_nx;
   logic                   half_q, half_nx;
   req_t                   req_q, cur_req;
   logic [ADDR_BITS-2:0]   word_q, cur_word;
   logic [SRAM_DATA_W-1:0] rd_lo_q;
   logic                   is_rd, active, cnt_done;
   logic [1:0]             strb;

   logic [ADDR_BITS-1:0]   sram_addr_nx;
   logic [SRAM_DATA_W-1:0] dq_do_nx;
   logic                   dq_oe_nx, ce_n_nx, oe_n_nx, we_n_nx, lb_n_nx, ub_n_nx, ready_nx;
   logic                   cap_lo, cap_hi;

   // Byte-offset bits and bits above the SRAM window are decoded upstream.
   logic unused_addr;
   assign unused_addr = ^{extram_addr[31:ADDR_BITS+1], extram_addr[1:0]};

   extram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
      .clk    (clk),
      .resetn (resetn),
      .load   (state == ST_SETUP),
      .en     (state == ST_STROBE),
      .done_c (cnt_done)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= ST_IDLE;
         half_q <= HALF_LO;
      end else begin
         state  <= state_nx;
         half_q <= half_nx;
      end
   end

   // Next state plus next values of every registered SRAM/bus output.
   always_comb begin
      state_nx = state;
      half_nx  = half_q;
      if (state == ST_IDLE) begin
         cur_req.wstrb = extram_wstrb;
         cur_req.wdata = extram_wdata;
         cur_word      = extram_addr[ADDR_BITS:2];
      end else begin
         cur_req  = req_q;
         cur_word = word_q;
      end
      is_rd = (cur_req.wstrb == 4'b0000);

      case (state)
         ST_IDLE: begin
            if (extram_valid) begin
               state_nx = ST_SETUP;
               half_nx  = (extram_wstrb[1:0] == 2'b00 && extram_wstrb[3:2] != 2'b00) ? HALF_HI : HALF_LO;
            end
         end
         ST_SETUP:  state_nx = (WAIT_CYCLES == 0) ? ST_HOLD : ST_STROBE;
         ST_STROBE: if (cnt_done) state_nx = ST_HOLD;
         ST_HOLD: begin
            if (half_q == HALF_LO && (is_rd || req_q.wstrb[3:2] != 2'b00)) begin
               state_nx = ST_SETUP;
               half_nx  = HALF_HI;
            end else begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase

      strb   = (half_nx == HALF_HI) ? cur_req.wstrb[3:2] : cur_req.wstrb[1:0];
      active = (state_nx == ST_SETUP) || (state_nx == ST_STROBE) || (state_nx == ST_HOLD);

      ce_n_nx      = 1'b1;
      oe_n_nx      = 1'b1;
      we_n_nx      = 1'b1;
      lb_n_nx      = 1'b1;
      ub_n_nx      = 1'b1;
      dq_oe_nx     = 1'b0;
      sram_addr_nx = sram_addr;
      dq_do_nx     = sram_dq_do;
      ready_nx     = (state_nx == ST_DONE);

      if (active) begin
         ce_n_nx      = 1'b0;
         sram_addr_nx = {cur_word, half_nx};
         if (is_rd) begin
            lb_n_nx = 1'b0;
            ub_n_nx = 1'b0;
            oe_n_nx = 1'b0;
         end else begin
            dq_oe_nx = 1'b1;
            dq_do_nx = (half_nx == HALF_HI) ? cur_req.wdata[31:16] : cur_req.wdata[15:0];
            lb_n_nx  = ~strb[0];
            ub_n_nx  = ~strb[1];
            we_n_nx  = (state_nx != ST_STROBE);
         end
      end

      cap_lo = (state == ST_HOLD) && is_rd && (half_q == HALF_LO);
      cap_hi = (state == ST_HOLD) && is_rd && (half_q == HALF_HI);
   end

   // Request latch and low-half read capture.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req_q   <= '0;
         word_q  <= '0;
         rd_lo_q <= '0;
      end else begin
         if (state == ST_IDLE && extram_valid) begin
            req_q.wstrb <= extram_wstrb;
            req_q.wdata <= extram_wdata;
            word_q      <= extram_addr[ADDR_BITS:2];
         end
         if (cap_lo)
            rd_lo_q <= sram_dq_di;
      end
   end

   // All pad and bus outputs come straight from flops.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_lb_n    <= 1'b1;
         sram_ub_n    <= 1'b1;
         sram_dq_oe   <= 1'b0;
         sram_addr    <= '0;
         sram_dq_do   <= '0;
         extram_ready <= 1'b0;
         extram_rdata <= '0;
      end else begin
         sram_ce_n    <= ce_n_nx;
         sram_oe_n    <= oe_n_nx;
         sram_we_n    <= we_n_nx;
         sram_lb_n    <= lb_n_nx;
         sram_ub_n    <= ub_n_nx;
         sram_dq_oe   <= dq_oe_nx;
         sram_addr    <= sram_addr_nx;
         sram_dq_do   <= dq_do_nx;
         extram_ready <= ready_nx;
         if (cap_hi)
            extram_rdata <= {sram_dq_di, rd_lo_q};
      end
   end

endmodule
